// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and small helpers.
// Used by vga_timing and by the pixel generators (game_message etc.) so that
// every block agrees on visible area, sync windows and totals.
package vga_pkg;

   // Counter width for hcount/vcount; all totals must fit (<= 2047).
   localparam int unsigned CNT_W = 11;

   // Default timing: 50 MHz system clock, 25 MHz pixel rate.
   localparam int unsigned DEF_CLK_DIV = 2;

   localparam int unsigned DEF_H_VIS  = 640;
   localparam int unsigned DEF_H_FP   = 16;
   localparam int unsigned DEF_H_SYNC = 96;
   localparam int unsigned DEF_H_BP   = 48;

   localparam int unsigned DEF_V_VIS  = 480;
   localparam int unsigned DEF_V_FP   = 10;
   localparam int unsigned DEF_V_SYNC = 2;
   localparam int unsigned DEF_V_BP   = 33;

   // Derived totals (800 x 525 with the defaults).
   localparam int unsigned H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Sync windows, [start, end): columns 656..751, lines 490..491.
   localparam int unsigned H_SYNC_START = DEF_H_VIS + DEF_H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
   localparam int unsigned V_SYNC_START = DEF_V_VIS + DEF_V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

   typedef logic [CNT_W-1:0] cnt_t;

   // True when lo <= c < hi (unsigned compare).
   function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: counts 0..DIV-1 and raises tick for the one cycle in
// which the count equals DIV-1.
// Ports: clk (system clock), rst (async, active-low), tick (registered enable).
module clk_en_div #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Next count and a tick that lines up with the cycle where count == DIV-1.
   always_comb begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      tick_d = (cnt_d == LAST);
   end

   // With DIV=1 the count sits at DIV-1 permanently, so tick is high out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= (DIV == 1);
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: pixel/line counters plus sync, blank and tick decode.
// Ports: clk, rst (async, active-low); hcount/vcount (11-bit position);
// hsync/vsync (active-low); blank (high outside visible area);
// pix_tick (1 clk after each advance); frame_tick (1 clk on wrap to (0,0)).
// All decoded outputs are computed from the next counter values so they
// change on the same edge as hcount/vcount.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV,
   parameter int unsigned H_VIS   = DEF_H_VIS,
   parameter int unsigned H_FP    = DEF_H_FP,
   parameter int unsigned H_SYNC  = DEF_H_SYNC,
   parameter int unsigned H_BP    = DEF_H_BP,
   parameter int unsigned V_VIS   = DEF_V_VIS,
   parameter int unsigned V_FP    = DEF_V_FP,
   parameter int unsigned V_SYNC  = DEF_V_SYNC,
   parameter int unsigned V_BP    = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             blank,
   output logic             pix_tick,
   output logic             frame_tick
);

   localparam cnt_t H_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam cnt_t HS_BEG = CNT_W'(H_VIS + H_FP);
   localparam cnt_t HS_END = CNT_W'(H_VIS + H_FP + H_SYNC);
   localparam cnt_t VS_BEG = CNT_W'(V_VIS + V_FP);
   localparam cnt_t VS_END = CNT_W'(V_VIS + V_FP + V_SYNC);
   localparam cnt_t H_VIS_C = CNT_W'(H_VIS);
   localparam cnt_t V_VIS_C = CNT_W'(V_VIS);

   logic tick;

   cnt_t hcount_q, hcount_d;
   cnt_t vcount_q, vcount_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic blank_q, blank_d;
   logic pix_tick_q, pix_tick_d;
   logic frame_tick_q, frame_tick_d;

   clk_en_div #(
      .DIV (CLK_DIV)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Counter advance and decode of the values the counters are about to take.
   always_comb begin
      hcount_d     = hcount_q;
      vcount_d     = vcount_q;
      pix_tick_d   = tick;
      frame_tick_d = 1'b0;

      if (tick) begin
         // >= rather than == keeps the counters in range even from a bad state.
         if (hcount_q >= H_LAST) begin
            hcount_d = '0;
            if (vcount_q >= V_LAST) begin
               vcount_d     = '0;
               frame_tick_d = 1'b1;
            end else begin
               vcount_d = vcount_q + CNT_W'(1);
            end
         end else begin
            hcount_d = hcount_q + CNT_W'(1);
         end
      end

      hsync_d = ~in_window(hcount_d, HS_BEG, HS_END);
      vsync_d = ~in_window(vcount_d, VS_BEG, VS_END);
      blank_d = (hcount_d >= H_VIS_C) || (vcount_d >= V_VIS_C);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcount_q     <= '0;
         vcount_q     <= '0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         blank_q      <= 1'b0;
         pix_tick_q   <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         blank_q      <= blank_d;
         pix_tick_q   <= pix_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign hcount     = hcount_q;
   assign vcount     = vcount_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign blank      = blank_q;
   assign pix_tick   = pix_tick_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving system clocks per pixel (50 MHz clk to 25 MHz pixel rate).
REQ-002 The block SHALL have parameters H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48, which set horizontal visible, front porch, sync and back porch pixels.
REQ-003 The block SHALL have parameters V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33, which set vertical visible, front porch, sync and back porch lines.
REQ-004 Port clk SHALL be an input, 1 bit wide: the system clock; it is the only clock and all logic is on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-006 Port hcount SHALL be an output, 11 bits wide: the current pixel column, 0..H_TOTAL-1.
REQ-007 Port vcount SHALL be an output, 11 bits wide: the current line, 0..V_TOTAL-1.
REQ-008 Port hsync SHALL be an output, 1 bit wide: horizontal sync, active-low.
REQ-009 Port vsync SHALL be an output, 1 bit wide: vertical sync, active-low.
REQ-010 Port blank SHALL be an output, 1 bit wide: high outside the visible area; the downstream pixel generators drive r/g/b low while it is high.
REQ-011 Port pix_tick SHALL be an output, 1 bit wide: a 1-clk pulse each time hcount/vcount advance.
REQ-012 Port frame_tick SHALL be an output, 1 bit wide: a 1-clk pulse when the counters wrap to (0,0).

Function
REQ-013 H_TOTAL SHALL be H_VIS+H_FP+H_SYNC+H_BP, which is 800 with the defaults.
REQ-014 V_TOTAL SHALL be V_VIS+V_FP+V_SYNC+V_BP, which is 525 with the defaults.
REQ-015 The divider SHALL count 0..CLK_DIV-1 and wrap to 0; an internal tick SHALL be asserted on the cycle it equals CLK_DIV-1.
REQ-016 On each tick, hcount SHALL increment.
REQ-017 On a tick with hcount=H_TOTAL-1, hcount SHALL go to 0 and vcount SHALL increment.
REQ-018 On a tick with hcount=H_TOTAL-1 and vcount=V_TOTAL-1, both counts SHALL go to 0.
REQ-019 Between ticks, hcount and vcount SHALL hold their values.
REQ-020 The outputs hsync, vsync, blank, pix_tick and frame_tick SHALL be registered and SHALL update on the same clk edge as the counters they describe, with zero cycles of skew to hcount/vcount.
REQ-021 hsync SHALL be 0 iff H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC, i.e. columns 656..751 with the defaults.
REQ-022 vsync SHALL be 0 iff V_VIS+V_FP <= vcount < V_VIS+V_FP+V_SYNC, i.e. lines 490..491 with the defaults.
REQ-023 blank SHALL be 1 iff hcount >= H_VIS or vcount >= V_VIS.
REQ-024 pix_tick SHALL be high for exactly the one clk following each counter advance.
REQ-025 frame_tick SHALL be high for exactly the one clk in which the counters first show (0,0) after a wrap, and never on the reset value.
REQ-026 With CLK_DIV=1, the tick SHALL be asserted every cycle, so the counters advance each clk.
REQ-027 hcount and vcount SHALL never exceed H_TOTAL-1 and V_TOTAL-1 respectively.
REQ-028 Counter comparisons SHALL be 11-bit unsigned, and every total SHALL be <= 2047.

Reset
REQ-029 While rst=0, the divider, hcount and vcount SHALL be 0, hsync=1, vsync=1, blank=0, pix_tick=0 and frame_tick=0, independent of clk.
REQ-030 Reset asserted mid-frame SHALL return all state to these values immediately; no partial line or frame SHALL be completed.
REQ-031 After rst deasserts, the first counter advance, to hcount=1, SHALL occur on the CLK_DIV-th rising clk edge.

Structure
REQ-032 Package vga_pkg SHALL hold the default timing constants, the derived H_TOTAL/V_TOTAL and the sync start/end constants; they are shared with game_message and the other pixel generators.
REQ-033 The divider SHALL be the single sub-module clk_en_div, with parameter DIV and ports clk, rst and tick.
REQ-034 The counters and sync/blank decode SHALL reside in vga_timing itself.

Verification
REQ-035 The bench SHALL check reset: rst=0 held 5 clks, then released -> counts stay 0 and hsync=vsync=1, blank=0, ticks 0; hcount=1 on the 2nd clk after release.
REQ-036 The bench SHALL check the line wrap: with the defaults, run 1600 clks -> hcount wraps 799->0 and vcount goes 0->1 on the same edge; blank rises at hcount=640.
REQ-037 The bench SHALL check hsync: over one line -> hsync low for exactly 96 pixel ticks (192 clks), starting at hcount=656 and rising at hcount=752.
REQ-038 The bench SHALL check a full frame: run 840000 clks -> exactly one frame_tick, coincident with (0,0); vsync low only on lines 490-491; blank high for all vcount >= 480.
REQ-039 The bench SHALL check reset mid-operation: assert rst asynchronously at hcount=300, vcount=200, between clk edges -> outputs take their reset values before the next edge; after release, timing resumes per REQ-031.
REQ-040 The bench SHALL check CLK_DIV=1: run 800 clks -> one full line, with pix_tick high every cycle.
